// File: rtl/mem_arb_bridge_pkg.sv
// Shared definitions for mem_arb_bridge: FSM encoding, MIPS segment constants
// and the virtual-to-physical address translation helpers.
package mem_arb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] SEG_KSEG0 = 3'b100;
   localparam logic [2:0] SEG_KSEG1 = 3'b101;

   // kseg0 and kseg1 both alias the low 512 MB of physical memory
   function automatic logic [31:0] xlate_addr(input logic [31:0] addr);
      if ((addr[31:29] == SEG_KSEG0) || (addr[31:29] == SEG_KSEG1)) begin
         xlate_addr = {3'b000, addr[28:0]};
      end else begin
         xlate_addr = addr;
      end
   endfunction

   function automatic logic is_uncached(input logic [31:0] addr);
      is_uncached = (addr[31:29] == SEG_KSEG1);
   endfunction

endpackage

// File: rtl/mem_arb_bridge_arbiter.sv
// Round-robin selector: grants the first requester at or after the pointer.
module rr_arbiter #(
   parameter int NCH = 2,
   parameter int PW  = 1
) (
   input  logic [NCH-1:0] req,
   input  logic [PW-1:0]  ptr,
   output logic [NCH-1:0] grant
);

   // scan channels starting at ptr, wrapping around
   always_comb begin
      logic found_s;
      int   idx_s;
      grant   = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int i = 0; i < NCH; i++) begin
         idx_s = (int'(ptr) + i) % NCH;
         if (!found_s && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/mem_arb_bridge.sv
// Multi-channel memory bridge: round-robin arbitration, kseg0/kseg1 address
// translation, single outstanding memory access with ack timeout.
module mem_arb_bridge
   import mem_arb_bridge_pkg::*;
#(
   parameter int NCH = 2,
   parameter int DW  = 32,
   parameter int TMO = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req_en,
   input  logic [NCH*DW/8-1:0] req_wen,
   input  logic [NCH*32-1:0] req_addr,
   input  logic [NCH*DW-1:0] req_wdata,
   output logic [NCH-1:0]    req_ready,
   output logic [NCH-1:0]    rsp_valid,
   output logic [NCH-1:0]    rsp_err,
   output logic [NCH*DW-1:0] rsp_rdata,
   output logic              mem_req,
   output logic [DW/8-1:0]   mem_wen,
   output logic [31:0]       mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic              mem_uncached,
   input  logic              mem_ack,
   input  logic [DW-1:0]     mem_rdata
);

   localparam int BW = DW / 8;
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

   state_t            state_r, state_s;
   logic [PW-1:0]     rr_ptr_r, gidx_r, gidx_s, ptr_next_s;
   logic [15:0]       cnt_r;
   logic [BW-1:0]     wen_r;
   logic [31:0]       addr_r, raw_addr_s;
   logic [DW-1:0]     wdata_r;
   logic              unc_r, err_r, tmo_hit_s;
   logic [NCH*DW-1:0] rdata_r;
   logic [NCH-1:0]    grant_s;

   rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
      .req   (req_en),
      .ptr   (rr_ptr_r),
      .grant (grant_s)
   );

   // one-hot grant to index, pointer successor and timeout detection
   always_comb begin
      gidx_s = '0;
      for (int i = 0; i < NCH; i++) begin
         gidx_s = gidx_s | (grant_s[i] ? PW'(i) : {PW{1'b0}});
      end
      if (gidx_s == PW'(NCH - 1)) begin
         ptr_next_s = {PW{1'b0}};
      end else begin
         ptr_next_s = gidx_s + PW'(1);
      end
      raw_addr_s = req_addr[int'(gidx_s)*32 +: 32];
      tmo_hit_s  = (state_r == ST_BUSY) && !mem_ack && (cnt_r == TMO_LAST);
   end

   // next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (|req_en) state_s = ST_BUSY;
            else         state_s = ST_IDLE;
         end
         ST_BUSY: begin
            if (mem_ack || tmo_hit_s) state_s = ST_RESP;
            else                      state_s = ST_BUSY;
         end
         ST_RESP: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_s;
   end

   // request latch, wait counter and per-channel read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r <= '0;
         gidx_r   <= '0;
         cnt_r    <= 16'd0;
         wen_r    <= '0;
         addr_r   <= 32'd0;
         wdata_r  <= '0;
         unc_r    <= 1'b0;
         err_r    <= 1'b0;
         rdata_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|req_en) begin
                  gidx_r   <= gidx_s;
                  rr_ptr_r <= ptr_next_s;
                  wen_r    <= req_wen[int'(gidx_s)*BW +: BW];
                  addr_r   <= xlate_addr(raw_addr_s);
                  unc_r    <= is_uncached(raw_addr_s);
                  wdata_r  <= req_wdata[int'(gidx_s)*DW +: DW];
                  cnt_r    <= 16'd0;
                  err_r    <= 1'b0;
               end
            end
            ST_BUSY: begin
               // an ack in the final counted cycle still wins over the timeout
               if (mem_ack) begin
                  if (wen_r == '0) rdata_r[int'(gidx_r)*DW +: DW] <= mem_rdata;
               end else if (tmo_hit_s) begin
                  err_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign req_ready    = ((state_r == ST_IDLE) && !rst) ? grant_s : '0;
   assign rsp_valid    = (state_r == ST_RESP) ? (NCH'(1) << gidx_r) : '0;
   assign rsp_err      = rsp_valid & {NCH{err_r}};
   assign rsp_rdata    = rdata_r;
   assign mem_req      = (state_r == ST_BUSY);
   assign mem_wen      = wen_r;
   assign mem_addr     = addr_r;
   assign mem_wdata    = wdata_r;
   assign mem_uncached = unc_r;

endmodule
